// File: rtl/load_unit.sv
// load_unit: executes one MIPS load (lb, lbu, lh, lhu, lw) per request against a
// word-wide data memory over a req/ack handshake, then extends the addressed
// byte/halfword and pulses Done for register-file write-back.
//
// Ports:
//   CLK, RST        clock, synchronous active-low reset
//   Start, Addr,    load request (sampled in IDLE only), byte address, load type
//   LdType
//   Busy, Done      high outside IDLE / one-cycle completion pulse
//   Dout, Fault     extended result / 00 ok, 01 misaligned, 10 timeout, 11 illegal
//   MemReq, MemAddr memory read request and word address
//   MemAck, MemData memory acknowledge and read data (valid in the ack cycle)
module load_unit #(
    parameter bit          BIG_ENDIAN = 1'b0,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Start,
    input  logic [31:0] Addr,
    input  logic [2:0]  LdType,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Dout,
    output logic [1:0]  Fault,
    output logic        MemReq,
    output logic [31:0] MemAddr,
    input  logic        MemAck,
    input  logic [31:0] MemData
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {IDLE, REQ, RESP, FLT} state_t;

    state_t             state;
    logic [2:0]         ld_type;
    logic [1:0]         k;
    logic [CNT_W-1:0]   cnt;

    logic [1:0]         byte_lane_c;
    logic               half_lane_c;
    logic [7:0]         lane_b_c;
    logic [15:0]        lane_h_c;
    logic [31:0]        ext_c;
    logic [1:0]         chk_c;

    // Lane selection and extension of the memory word for the latched request.
    // Big-endian lanes are the mirror image, so 3-k is just ~k on two bits.
    always_comb begin
        byte_lane_c = BIG_ENDIAN ? ~k : k;
        half_lane_c = BIG_ENDIAN ? ~k[1] : k[1];
        lane_b_c    = MemData[{byte_lane_c, 3'b000} +: 8];
        lane_h_c    = MemData[{half_lane_c, 4'b0000} +: 16];
        case (ld_type)
            3'b000:  ext_c = {{24{lane_b_c[7]}}, lane_b_c};
            3'b001:  ext_c = {{16{lane_h_c[15]}}, lane_h_c};
            3'b100:  ext_c = {24'h0, lane_b_c};
            3'b101:  ext_c = {16'h0, lane_h_c};
            default: ext_c = MemData;
        endcase
    end

    // Request screening: illegal type takes priority over misalignment.
    always_comb begin
        chk_c = 2'b00;
        case (LdType)
            3'b000, 3'b100: chk_c = 2'b00;
            3'b001, 3'b101: chk_c = Addr[0] ? 2'b01 : 2'b00;
            3'b010:         chk_c = (Addr[1:0] != 2'b00) ? 2'b01 : 2'b00;
            default:        chk_c = 2'b11;
        endcase
    end

    // Control FSM with registered outputs.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state   <= IDLE;
            ld_type <= 3'b000;
            k       <= 2'b00;
            cnt     <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            Dout    <= 32'h0;
            Fault   <= 2'b00;
            MemReq  <= 1'b0;
            MemAddr <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        ld_type <= LdType;
                        k       <= Addr[1:0];
                        MemAddr <= {Addr[31:2], 2'b00};
                        cnt     <= '0;
                        Busy    <= 1'b1;
                        if (chk_c != 2'b00) begin
                            Fault <= chk_c;
                            Done  <= 1'b1;
                            state <= FLT;
                        end else begin
                            MemReq <= 1'b1;
                            state  <= REQ;
                        end
                    end
                end
                REQ: begin
                    // An ack in the final allowed cycle still completes normally.
                    if (MemAck) begin
                        Dout   <= ext_c;
                        Fault  <= 2'b00;
                        MemReq <= 1'b0;
                        Done   <= 1'b1;
                        state  <= RESP;
                    end else if (cnt + CNT_W'(1) == CNT_W'(TIMEOUT)) begin
                        Fault  <= 2'b10;
                        MemReq <= 1'b0;
                        Done   <= 1'b1;
                        state  <= FLT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP, FLT: begin
                    Done  <= 1'b0;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_unit.sv
// tb_load_unit: drives two load_unit instances (little-endian with TIMEOUT=4,
// big-endian with TIMEOUT=255) through directed and random loads, checking
// cycle timing and results against a behavioural model of the load rules.
module tb_load_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   [2];
    logic        start [2];
    logic        ack   [2];
    logic [31:0] addr  [2];
    logic [31:0] mdata [2];
    logic [2:0]  lt    [2];
    logic        busy  [2];
    logic        done  [2];
    logic        mreq  [2];
    logic [31:0] dout  [2];
    logic [31:0] maddr [2];
    logic [1:0]  fault [2];

    load_unit #(.BIG_ENDIAN(1'b0), .TIMEOUT(4)) u_le (
        .CLK(clk), .RST(rst[0]), .Start(start[0]), .Addr(addr[0]), .LdType(lt[0]),
        .Busy(busy[0]), .Done(done[0]), .Dout(dout[0]), .Fault(fault[0]),
        .MemReq(mreq[0]), .MemAddr(maddr[0]), .MemAck(ack[0]), .MemData(mdata[0])
    );

    load_unit #(.BIG_ENDIAN(1'b1), .TIMEOUT(255)) u_be (
        .CLK(clk), .RST(rst[1]), .Start(start[1]), .Addr(addr[1]), .LdType(lt[1]),
        .Busy(busy[1]), .Done(done[1]), .Dout(dout[1]), .Fault(fault[1]),
        .MemReq(mreq[1]), .MemAddr(maddr[1]), .MemAck(ack[1]), .MemData(mdata[1])
    );

    int          n_pass = 0;
    int          n_total = 0;
    int          done_cnt [2] = '{0, 0};
    int          accepted [2] = '{0, 0};
    logic [31:0] last_dout [2] = '{32'h0, 32'h0};

    // Counts every Done pulse seen at a clock edge.
    always @(posedge clk) begin
        if (done[0]) done_cnt[0] <= done_cnt[0] + 1;
        if (done[1]) done_cnt[1] <= done_cnt[1] + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference load: returns {fault, value} straight from the load rules.
    function automatic logic [33:0] ref_load(input bit be, input logic [2:0] t,
                                             input logic [31:0] a, input logic [31:0] d);
        int     lane;
        longint v;
        case (t)
            3'b000, 3'b100: begin
                lane = be ? 3 - int'(a[1:0]) : int'(a[1:0]);
                v = longint'((d >> (8 * lane)) & 32'hFF);
                if (t == 3'b000 && v > 127) v = v - 256;
                return {2'b00, 32'(v)};
            end
            3'b001, 3'b101: begin
                if (a[0]) return {2'b01, 32'h0};
                lane = be ? 1 - int'(a[1]) : int'(a[1]);
                v = longint'((d >> (16 * lane)) & 32'hFFFF);
                if (t == 3'b001 && v > 32767) v = v - 65536;
                return {2'b00, 32'(v)};
            end
            3'b010: begin
                if (a[1:0] != 2'b00) return {2'b01, 32'h0};
                return {2'b00, d};
            end
            default: return {2'b11, 32'h0};
        endcase
    endfunction

    // One load on instance i; the ack arrives in REQ cycle nwait+1 (never if
    // that is past the instance's timeout). A Start is also offered while busy
    // and during the Done cycle, both of which must be ignored.
    task automatic run(input int i, input logic [2:0] t, input logic [31:0] a,
                       input logic [31:0] d, input int nwait);
        logic [33:0] r;
        int          tmo;
        logic        hit;
        r   = ref_load(i == 1, t, a, d);
        tmo = (i == 0) ? 4 : 255;
        start[i] = 1'b1; addr[i] = a; lt[i] = t;
        tick();
        start[i] = 1'b0;
        accepted[i]++;
        if (r[33:32] != 2'b00) begin
            chk("early_done", 32'(done[i]), 32'd1);
            chk("early_fault", 32'(fault[i]), 32'(r[33:32]));
            chk("early_busy", 32'(busy[i]), 32'd1);
            chk("early_memreq", 32'(mreq[i]), 32'd0);
            chk("early_dout_kept", dout[i], last_dout[i]);
        end else begin
            for (int c = 1; c <= tmo; c++) begin
                chk("req_memreq", 32'(mreq[i]), 32'd1);
                chk("req_memaddr", maddr[i], a & 32'hFFFF_FFFC);
                chk("req_busy", 32'(busy[i]), 32'd1);
                chk("req_done", 32'(done[i]), 32'd0);
                hit = (c == nwait + 1);
                ack[i]   = hit;
                mdata[i] = hit ? d : $urandom;
                if (c == 1) begin
                    start[i] = 1'b1; addr[i] = $urandom; lt[i] = 3'b010;
                end
                tick();
                start[i] = 1'b0; ack[i] = 1'b0; mdata[i] = $urandom;
                if (hit) begin
                    chk("resp_done", 32'(done[i]), 32'd1);
                    chk("resp_fault", 32'(fault[i]), 32'd0);
                    chk("resp_dout", dout[i], r[31:0]);
                    chk("resp_memreq", 32'(mreq[i]), 32'd0);
                    last_dout[i] = r[31:0];
                    break;
                end
                if (c == tmo) begin
                    chk("tmo_done", 32'(done[i]), 32'd1);
                    chk("tmo_fault", 32'(fault[i]), 32'd2);
                    chk("tmo_dout_kept", dout[i], last_dout[i]);
                    chk("tmo_memreq", 32'(mreq[i]), 32'd0);
                end
            end
        end
        // Start during the Done cycle must not be taken.
        start[i] = 1'b1; addr[i] = {$urandom_range(0, 1023), 2'b00}; lt[i] = 3'b010;
        tick();
        start[i] = 1'b0;
        chk("after_busy", 32'(busy[i]), 32'd0);
        chk("after_done", 32'(done[i]), 32'd0);
        chk("after_memreq", 32'(mreq[i]), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b0; start[i] = 1'b0; ack[i] = 1'b0;
            addr[i] = 32'h0; mdata[i] = 32'h0; lt[i] = 3'b000;
        end
        tick(); tick();
        for (int i = 0; i < 2; i++) begin
            chk("rst_busy", 32'(busy[i]), 32'd0);
            chk("rst_done", 32'(done[i]), 32'd0);
            chk("rst_memreq", 32'(mreq[i]), 32'd0);
            chk("rst_memaddr", maddr[i], 32'h0);
            chk("rst_dout", dout[i], 32'h0);
            chk("rst_fault", 32'(fault[i]), 32'd0);
        end
        rst[0] = 1'b1; rst[1] = 1'b1;
        tick();

        run(0, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 0);
        chk("tp_lw", dout[0], 32'hDEAD_BEEF);
        run(0, 3'b000, 32'h0000_0013, 32'h80FF_7F01, 0);
        chk("tp_lb", dout[0], 32'hFFFF_FF80);
        run(0, 3'b100, 32'h0000_0013, 32'h80FF_7F01, 0);
        chk("tp_lbu", dout[0], 32'h0000_0080);
        run(1, 3'b000, 32'h0000_0013, 32'h80FF_7F01, 0);
        chk("tp_lb_be", dout[1], 32'h0000_0001);
        run(0, 3'b001, 32'h0000_0022, 32'h8001_7FFF, 3);
        chk("tp_lh_wait", dout[0], 32'hFFFF_8001);
        run(0, 3'b010, 32'h0000_0006, 32'h1234_5678, 0);
        run(0, 3'b001, 32'h0000_0001, 32'h1234_5678, 0);
        run(0, 3'b011, 32'h0000_0040, 32'h1234_5678, 0);
        chk("tp_fault_dout_kept", dout[0], 32'hFFFF_8001);
        run(0, 3'b010, 32'h0000_0100, 32'hCAFE_F00D, 4);
        chk("tp_timeout_dout_kept", dout[0], 32'hFFFF_8001);
        run(0, 3'b010, 32'h0000_0104, 32'hCAFE_F00D, 3);
        chk("tp_ack_at_limit", dout[0], 32'hCAFE_F00D);

        // Reset mid-REQ, then a late ack: nothing may complete.
        start[0] = 1'b1; addr[0] = 32'h0000_0040; lt[0] = 3'b010;
        tick();
        start[0] = 1'b0;
        chk("mid_req_memreq", 32'(mreq[0]), 32'd1);
        tick();
        rst[0] = 1'b0;
        tick();
        rst[0] = 1'b1;
        chk("mid_rst_busy", 32'(busy[0]), 32'd0);
        chk("mid_rst_memreq", 32'(mreq[0]), 32'd0);
        chk("mid_rst_memaddr", maddr[0], 32'h0);
        chk("mid_rst_dout", dout[0], 32'h0);
        chk("mid_rst_fault", 32'(fault[0]), 32'd0);
        ack[0] = 1'b1; mdata[0] = $urandom;
        tick();
        ack[0] = 1'b0;
        chk("late_ack_done", 32'(done[0]), 32'd0);
        chk("late_ack_dout", dout[0], 32'h0);
        tick();
        chk("late_ack_done2", 32'(done[0]), 32'd0);
        chk("late_ack_busy", 32'(busy[0]), 32'd0);
        last_dout[0] = 32'h0;

        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < 2; i++) begin
                run(i, 3'($urandom_range(0, 7)), $urandom, $urandom, int'($urandom_range(0, 5)));
            end
        end

        tick();
        chk("done_count_le", 32'(done_cnt[0]), 32'(accepted[0]));
        chk("done_count_be", 32'(done_cnt[1]), 32'(accepted[1]));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
